// File: rtl/act_lut_requester.sv
// Activation LUT requester: converts signed sums to LUT addresses, issues
// reads to the activation memory and returns results over valid/ready.
//
// Ports:
//   clk, rst_n             clock (rising edge) and async active-low reset
//   in_valid/in_ready      input handshake, in_sum = signed pre-activation
//   out_valid/out_ready    output handshake, out_act = mem_dout[23:0]
//   mem_din, mem_addr      read enable and signed address to the LUT
//   mem_dout               LUT read data, upper byte unused
//   sat_cnt                number of clamped inputs, saturating at 255
module act_lut_requester #(
    parameter int IN_W      = 16,
    parameter int SHIFT     = 4,
    parameter int MEM_LAT   = 1,
    parameter int BUF_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [23:0]            out_act,
    output logic                   mem_din,
    output logic [7:0]             mem_addr,
    input  logic [31:0]            mem_dout,
    output logic [7:0]             sat_cnt
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + MEM_LAT + 2);

    localparam logic signed [IN_W-1:0] ADDR_MAX = IN_W'(127);
    localparam logic signed [IN_W-1:0] ADDR_MIN = ~ADDR_MAX;

    logic signed [IN_W-1:0] sh;
    logic                   hi;
    logic                   lo;
    logic [7:0]             addr_d;
    logic [7:0]             mem_addr_q;
    logic                   mem_din_q;
    logic [7:0]             sat_q;
    logic [7:0]             sat_d;

    logic [MEM_LAT:0]       vld_q;
    logic [23:0]            buf_q [BUF_DEPTH];
    logic [PW-1:0]          rd_q;
    logic [PW-1:0]          wr_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [23:0]            last_q;

    logic [CW-1:0]          inflight;
    logic [CW-1:0]          credit;
    logic                   acc;
    logic                   wr;
    logic                   pop;
    logic                   unused_hi;

    assign unused_hi = ^mem_dout[31:24];

    assign sh     = in_sum >>> SHIFT;
    assign hi     = sh > ADDR_MAX;
    assign lo     = sh < ADDR_MIN;
    assign addr_d = hi ? 8'h7F : (lo ? 8'h80 : sh[7:0]);

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= MEM_LAT; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign wr        = vld_q[MEM_LAT];

    // Credits cover both in-flight reads and buffered results, so a result
    // always has a free slot when it returns. A same-cycle pop frees one.
    assign credit   = inflight + cnt_q - CW'(pop);
    assign in_ready = rst_n && (credit < CW'(BUF_DEPTH));
    assign acc      = in_valid && in_ready;

    assign cnt_d = cnt_q + CW'(wr) - CW'(pop);
    assign sat_d = ((hi || lo) && (sat_q != 8'hFF)) ? sat_q + 8'd1 : sat_q;

    // Once drained, out_act keeps showing the last popped result.
    assign out_act  = out_valid ? buf_q[rd_q] : last_q;
    assign mem_din  = mem_din_q;
    assign mem_addr = mem_addr_q;
    assign sat_cnt  = sat_q;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_din_q  <= 1'b0;
            mem_addr_q <= '0;
            sat_q      <= '0;
            vld_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            mem_din_q <= acc;
            if (acc) begin
                mem_addr_q <= addr_d;
                sat_q      <= sat_d;
            end
            vld_q[0] <= acc;
            for (int i = 1; i <= MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (wr) begin
                buf_q[wr_q] <= mem_dout[23:0];
                wr_q        <= nxt(wr_q);
            end
            if (pop) begin
                last_q <= buf_q[rd_q];
                rd_q   <= nxt(rd_q);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_act_lut_requester.sv
// Bench for act_lut_requester: directed sums, synchronous LUT model,
// queue-based scoreboard drained by an independent output monitor.
module tb_act_lut_requester;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_sum = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [23:0]        out_act;
    logic               mem_din;
    logic [7:0]         mem_addr;
    logic [31:0]        mem_dout = '0;
    logic [7:0]         sat_cnt;

    act_lut_requester #(
        .IN_W(16), .SHIFT(4), .MEM_LAT(1), .BUF_DEPTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
        .mem_din(mem_din), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] lut [256];

    always @(posedge clk) begin
        if (mem_din) mem_dout <= {8'hA5, lut[mem_addr]};
    end

    logic [23:0] exp_q [$];
    int          pop_cyc [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0h, expected none",
                             out_act);
                end else begin
                    check("out_act", {8'h0, out_act},
                          {8'h0, exp_q.pop_front()});
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic send(input logic signed [15:0] s, input logic [7:0] ea,
                        output bit stalled, output int acc_cyc);
        int w = 0;
        stalled = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        #4;
        while (!in_ready && w < 100) begin
            stalled = 1'b1;
            w++;
            @(negedge clk);
            #4;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(lut[ea]);
            n_acc++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            acc_cyc  = cyc;
            check("mem_addr", 32'(mem_addr), 32'(ea));
            check("mem_din", 32'(mem_din), 32'd1);
        end
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_din", 32'(mem_din), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_out_act", 32'(out_act), 0);
        check("rst_sat_cnt", 32'(sat_cnt), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   st;
        bit   st_any;
        int   ac;
        int   base;
        int   w;
        logic [7:0] b;

        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            lut[i] = {b ^ 8'h3C, ~b, b + 8'd17};
        end
        lut[8'h2F] = 24'hF31D88;
        lut[8'h56] = 24'hFED1E8;
        lut[8'h49] = 24'hFD5B22;
        lut[8'h1C] = 24'hDA1994;
        lut[8'h3E] = 24'hFACB80;

        #3;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single request and its latency
        pop_cyc.delete();
        send(16'sd752, 8'h2F, st, ac);
        drain();
        check("latency", pop_cyc.size() > 0 ? pop_cyc[0] - ac : -1, 2);
        check("sat_single", 32'(sat_cnt), 0);

        // back-to-back stream, low bits dropped by the shift
        pop_cyc.delete();
        st_any = 1'b0;
        send(16'sd1381, 8'h56, st, ac); st_any |= st;
        send(16'sd1168, 8'h49, st, ac); st_any |= st;
        send(16'sd448,  8'h1C, st, ac); st_any |= st;
        send(16'sd992,  8'h3E, st, ac); st_any |= st;
        drain();
        check("stream_stall", 32'(st_any), 0);
        check("stream_n", pop_cyc.size(), 4);
        check("stream_consec",
              pop_cyc.size() == 4 ? pop_cyc[3] - pop_cyc[0] : -1, 3);

        // in-range edges and negative flooring
        send(-16'sd1,    8'hFF, st, ac);
        send(-16'sd20,   8'hFE, st, ac);
        send(16'sd2047,  8'h7F, st, ac);
        send(-16'sd2048, 8'h80, st, ac);
        drain();
        check("sat_edges", 32'(sat_cnt), 0);

        // clamping
        send(16'sd3000, 8'h7F, st, ac);
        check("sat_1", 32'(sat_cnt), 1);
        send(-16'sd4000, 8'h80, st, ac);
        check("sat_2", 32'(sat_cnt), 2);
        send(16'sd2048, 8'h7F, st, ac);
        send(-16'sd2049, 8'h80, st, ac);
        check("sat_4", 32'(sat_cnt), 4);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) send(16'sd30000, 8'h7F, st, ac);
            else            send(-16'sd30000, 8'h80, st, ac);
        end
        drain();
        check("sat_hold", 32'(sat_cnt), 255);

        // backpressure with 5 offered inputs
        @(negedge clk);
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                bit fst;
                int fac;
                for (int k = 0; k < 5; k++) begin
                    send(16'(16 * (16 + k)), 8'(16 + k), fst, fac);
                end
            end
        join_none
        repeat (8) @(negedge clk);
        #4;
        check("bp_accepted", n_acc - base, 3);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_head", 32'(out_act), 32'(lut[8'h10]));
        @(negedge clk);
        #4;
        check("bp_head_stable", 32'(out_act), 32'(lut[8'h10]));
        @(negedge clk);
        out_ready = 1'b1;
        w = 0;
        while (n_acc != base + 5 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("bp_all_accepted", n_acc - base, 5);
        @(negedge clk);
        drain();

        // write and pop together with two results buffered
        @(negedge clk);
        out_ready = 1'b0;
        send(16'sd512, 8'h20, st, ac);
        send(16'sd528, 8'h21, st, ac);
        repeat (3) @(negedge clk);
        send(16'sd544, 8'h22, st, ac);
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'sd560, 8'h23, st, ac);
        out_ready = 1'b0;
        check("wp_in_ready", 32'(st), 0);
        repeat (3) @(negedge clk);
        #4;
        check("wp_full", 32'(in_ready), 0);
        check("wp_head", 32'(out_act), 32'(lut[8'h21]));
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // reset with two requests in flight
        send(16'sd768, 8'h30, st, ac);
        send(16'sd784, 8'h31, st, ac);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #4;
        check("post_rst_idle", 32'(out_valid), 0);
        send(16'sd1024, 8'h40, st, ac);
        drain();
        check("post_rst_sat", 32'(sat_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
